switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Switch control logic that sits directly upstream of the mux-based crossbar switch in each router.
- Arbitrates head-flit requests from input ports for output ports with per-output round-robin.
- Holds each output-to-input path reserved until that packet's tail flit handshakes.
- Drives the crossbar's routeSelect, outputBusy and PortReserved from registers, so the crossbar sees stable selects.

Parameters:
INPUTS, 4, number of router input ports
OUTPUTS, 4, number of router output ports
REQUEST_WIDTH, 32, width of each per-port request / route-select word (carries a port index)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  INPUTS  input i has a head flit at buffer front with route computed
req_port  input  INPUTS x REQUEST_WIDTH  requested output index for input i
flit_tail  input  INPUTS  flit currently presented by input i is a tail flit (head==tail allowed)
valid_in  input  INPUTS  crossbar input-side valid (observed, not driven)
ready_in  input  INPUTS  crossbar input-side ready (observed, not driven)
routeSelect  output  OUTPUTS x REQUEST_WIDTH  registered; input index feeding output o
outputBusy  output  OUTPUTS  registered; output o holds a reservation
PortReserved  output  INPUTS  registered; input i owns a reserved path

Behaviour:
- Reset (rst_n=0 at a rising edge): on that edge all outputs go to 0, every per-output FSM goes to IDLE, and every round-robin pointer goes to 0. This overrides any in-flight packet, and no state survives.
- Per-output FSM has two states, IDLE and BUSY. owner[o] is the granted input index.
- Eligible inputs for output o: req_valid[i]=1, req_port[i]==o and PortReserved[i]=0.
- req_port values >= OUTPUTS are ignored; such an input never gets a grant.
- IDLE -> BUSY: if any input is eligible, grant the first eligible input at or after rr_ptr[o], searching upward with wrap-around modulo INPUTS. On the next edge:
  - outputBusy[o]=1, routeSelect[o]=grant, PortReserved[grant]=1;
  - rr_ptr[o]=(grant+1) mod INPUTS.
- Grant latency: exactly 1 cycle from the cycle the request is sampled to the cycle outputs reflect it.
- Input conflicts cannot occur: each input requests exactly one output, so distinct outputs may grant distinct inputs in the same cycle independently.
- BUSY -> IDLE: when valid_in[owner] & ready_in[owner] & flit_tail[owner] are all 1 in a cycle. On the next edge:
  - outputBusy[o]=0, PortReserved[owner]=0, routeSelect[o]=0;
  - rr_ptr[o] is unchanged.
- Non-tail handshakes and stalls (valid without ready) leave BUSY unchanged. There is no timeout.
- No grant is made in the release cycle. The earliest new grant on that output is sampled in the first IDLE cycle, so there is a 1-cycle bubble between packets on the same output (intended; keeps the crossbar select glitch-free).
- Single-flit packet: a head+tail handshake in the first BUSY cycle releases the path after exactly 1 BUSY cycle.
- Requests from an already-reserved input are ignored. This covers upstream req_valid remaining high during body flits.
- Invariant, checked by assertion: PortReserved[i]=1 iff exactly one output o has outputBusy[o]=1 and routeSelect[o]=i.
- Arithmetic: index compares are done at REQUEST_WIDTH bits. Internal pointers are $clog2(INPUTS) bits, zero-extended into routeSelect.

Decomposition:
- Shared package noc_pkg:
  - alloc_state_t enum {IDLE, BUSY};
  - IDX_W = $clog2(INPUTS) helper;
  - flit-type constants used to derive flit_tail upstream.
- One natural sub-module, rr_arbiter:
  - parameter N;
  - inputs: request vector, pointer;
  - outputs: one-hot grant, grant index, any_grant.
  - Combinational; instantiated OUTPUTS times. FSM and pointer registers live in switch_allocator.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with req_valid=4'b1111 -> all outputs 0 at each edge; after release, first grants appear exactly 1 cycle after the first sampled request.
2. Contention: inputs 1 and 3 both request output 2, rr_ptr[2]=0 -> cycle+1: routeSelect[2]=1, outputBusy[2]=1, PortReserved=4'b0010. Tail handshake on input 1 -> released next edge. One bubble cycle, then input 3 granted, routeSelect[2]=3.
3. Fairness: inputs 0..3 all repeatedly request output 0 with 1-flit packets -> grant order 0,1,2,3,0, each separated by 1 idle cycle.
4. Multi-flit with stall: input 2 -> output 1 with a 4-flit packet, ready_in[2] low for 3 cycles mid-packet -> BUSY held throughout. Release only on the edge after the tail handshake; a flit_tail seen with ready low does not release.
5. Parallel plus invalid request: input 0 -> output 3, input 1 -> output 0, input 2 req_port=7 in the same cycle -> both valid grants next cycle, PortReserved=4'b0011. Input 2 never granted.
6. Reset mid-packet: rst_n=0 while outputs 0 and 2 are BUSY -> all cleared on that edge. rr pointers return to 0, so the subsequent grant on output 0 picks the lowest requesting input.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and helpers for the router control slice.
package noc_pkg;

    // Per-output allocation state: free, or reserved for one packet.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alloc_state_t;

    // Index width for an N-entry port set; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Flit-type encoding carried in the flit header; bit 1 marks a tail.
    localparam logic [1:0] FLIT_HEAD      = 2'b00;
    localparam logic [1:0] FLIT_BODY      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    // Upstream logic derives flit_tail from the flit type with this.
    function automatic logic is_tail(input logic [1:0] flit_type);
        return flit_type[1];
    endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after
// the pointer, searching upward with wrap-around.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             any_grant_o
);

    logic [PTR_W-1:0] idx;

    // Rotating priority scan starting at the pointer; first hit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % N);
            if (!any_grant_o && req_i[idx]) begin
                any_grant_o  = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin grant of head flits, path held
// until the owning packet's tail flit handshakes. All crossbar-facing
// outputs come straight from flops.
//
// Handshake: a flit transfers on input i in any cycle where valid_in[i] and
// ready_in[i] are both 1; valid without ready is a stall and transfers
// nothing. The allocator only observes this handshake, it never drives it.
module switch_allocator
    import noc_pkg::*;
#(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int REQUEST_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [INPUTS-1:0]                     req_valid,
    input  logic [INPUTS-1:0][REQUEST_WIDTH-1:0]  req_port,
    input  logic [INPUTS-1:0]                     flit_tail,
    input  logic [INPUTS-1:0]                     valid_in,
    input  logic [INPUTS-1:0]                     ready_in,
    output logic [OUTPUTS-1:0][REQUEST_WIDTH-1:0] routeSelect,
    output logic [OUTPUTS-1:0]                    outputBusy,
    output logic [INPUTS-1:0]                     PortReserved,
    output alloc_state_t [OUTPUTS-1:0]            fsm_state_o
);

    localparam int IDX_W = idx_width(INPUTS);

    alloc_state_t [OUTPUTS-1:0]            state_q, state_d;
    logic [OUTPUTS-1:0][IDX_W-1:0]         owner_q, owner_d;
    logic [OUTPUTS-1:0][IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [INPUTS-1:0]                     reserved_q, reserved_d;

    logic [OUTPUTS-1:0][INPUTS-1:0]        eligible;
    logic [OUTPUTS-1:0][INPUTS-1:0]        grant_oh;
    logic [OUTPUTS-1:0][IDX_W-1:0]         grant_idx;
    logic [OUTPUTS-1:0]                    any_grant;
    logic [OUTPUTS-1:0]                    release_path;

    logic inv_ok;
    int   hits;

    // Eligibility: valid head, route matches this output at full width,
    // and the input does not already own a path. Out-of-range routes match
    // no output and are therefore never granted.
    always_comb begin
        eligible = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            for (int i = 0; i < INPUTS; i++) begin
                eligible[o][i] = req_valid[i]
                              && (req_port[i] == REQUEST_WIDTH'(o))
                              && !reserved_q[i];
            end
        end
    end

    for (genvar g = 0; g < OUTPUTS; g++) begin : g_arb
        rr_arbiter #(
            .N     (INPUTS),
            .PTR_W (IDX_W)
        ) u_arb (
            .req_i       (eligible[g]),
            .ptr_i       (rr_ptr_q[g]),
            .grant_o     (grant_oh[g]),
            .grant_idx_o (grant_idx[g]),
            .any_grant_o (any_grant[g])
        );
    end

    // Tail handshake on the owning input frees the path.
    always_comb begin
        release_path = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            release_path[o] = (state_q[o] == BUSY)
                           && valid_in[owner_q[o]]
                           && ready_in[owner_q[o]]
                           && flit_tail[owner_q[o]];
        end
    end

    // Next-state logic for every per-output FSM.
    always_comb begin
        state_d = state_q;
        for (int o = 0; o < OUTPUTS; o++) begin
            case (state_q[o])
                IDLE:    if (any_grant[o])    state_d[o] = BUSY;
                BUSY:    if (release_path[o]) state_d[o] = IDLE;
                default:                      state_d[o] = IDLE;
            endcase
        end
    end

    // Owner, pointer and reservation updates driven by grants and releases.
    // A released input cannot be granted elsewhere in the same cycle because
    // it is still reserved, so set and clear never collide on one bit.
    always_comb begin
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        reserved_d = reserved_q;
        for (int o = 0; o < OUTPUTS; o++) begin
            if (state_q[o] == IDLE && any_grant[o]) begin
                owner_d[o]                = grant_idx[o];
                rr_ptr_d[o]               = (grant_idx[o] == IDX_W'(INPUTS - 1))
                                            ? '0 : grant_idx[o] + 1'b1;
                reserved_d[grant_idx[o]]  = 1'b1;
            end else if (release_path[o]) begin
                owner_d[o]                = '0;
                reserved_d[owner_q[o]]    = 1'b0;
            end
        end
    end

    // State register; synchronous reset discards any in-flight packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < OUTPUTS; o++) begin
                state_q[o]  <= IDLE;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
            reserved_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            reserved_q <= reserved_d;
        end
    end

    // Crossbar-facing outputs are pure flop decodes, so selects never glitch.
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            routeSelect[o] = REQUEST_WIDTH'(owner_q[o]);
            outputBusy[o]  = (state_q[o] == BUSY);
        end
        PortReserved = reserved_q;
        fsm_state_o  = state_q;
    end

    // Reservation invariant: an input is reserved iff exactly one busy
    // output selects it.
    always_comb begin
        inv_ok = 1'b1;
        hits   = 0;
        for (int i = 0; i < INPUTS; i++) begin
            hits = 0;
            for (int o = 0; o < OUTPUTS; o++) begin
                if (state_q[o] == BUSY && owner_q[o] == IDX_W'(i)) hits = hits + 1;
            end
            if (reserved_q[i] != (hits == 1)) inv_ok = 1'b0;
        end
    end

    // Flag any break of the reservation invariant while out of reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (inv_ok) else $error("switch_allocator: reservation invariant violated");
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, contention, fairness, stalled
// multi-flit packet, parallel/invalid routes and reset mid-packet.
module tb_switch_allocator;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req_valid;
    logic [3:0][31:0]  req_port;
    logic [3:0]        flit_tail;
    logic [3:0]        valid_in;
    logic [3:0]        ready_in;
    logic [3:0][31:0]  route_select;
    logic [3:0]        output_busy;
    logic [3:0]        port_reserved;
    logic [3:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    switch_allocator #(
        .INPUTS        (4),
        .OUTPUTS       (4),
        .REQUEST_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_port     (req_port),
        .flit_tail    (flit_tail),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .routeSelect  (route_select),
        .outputBusy   (output_busy),
        .PortReserved (port_reserved),
        .fsm_state_o  (state_dbg)
    );

    // Clock and safety timeout.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_port  = '0;
        flit_tail = '0;
        valid_in  = '0;
        ready_in  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_outs(input string tag, input logic [3:0] busy, input logic [3:0] res);
        check({tag, ".busy"}, 32'(output_busy), 32'(busy));
        check({tag, ".reserved"}, 32'(port_reserved), 32'(res));
        check({tag, ".state"}, 32'(state_dbg), 32'(busy));
    endtask

    task automatic expect_route(input string tag, input int o, input logic [31:0] exp);
        check($sformatf("%s.route%0d", tag, o), route_select[o], exp);
    endtask

    task automatic handshake(input int i, input logic v, input logic r, input logic t);
        valid_in[i]  = v;
        ready_in[i]  = r;
        flit_tail[i] = t;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // 1. Reset with all requests high; grants appear one edge after release.
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) req_port[i] = 32'(i);
        for (int c = 0; c < 2; c++) begin
            tick();
            expect_outs("t1_rst", 4'b0000, 4'b0000);
            for (int o = 0; o < 4; o++) expect_route("t1_rst", o, 32'd0);
        end
        rst_n = 1'b1;
        tick();
        expect_outs("t1_grant", 4'b1111, 4'b1111);
        for (int o = 0; o < 4; o++) expect_route("t1_grant", o, 32'(o));

        // 2. Contention on output 2 between inputs 1 and 3.
        do_reset();
        req_valid[1] = 1'b1; req_port[1] = 32'd2;
        req_valid[3] = 1'b1; req_port[3] = 32'd2;
        tick();
        expect_outs("t2_grant1", 4'b0100, 4'b0010);
        expect_route("t2_grant1", 2, 32'd1);
        req_valid[1] = 1'b0;
        handshake(1, 1'b1, 1'b1, 1'b1);
        tick();
        expect_outs("t2_release", 4'b0000, 4'b0000);
        expect_route("t2_release", 2, 32'd0);
        handshake(1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outs("t2_grant3", 4'b0100, 4'b1000);
        expect_route("t2_grant3", 2, 32'd3);

        // 3. Fairness on output 0 with single-flit packets.
        do_reset();
        req_valid = 4'b1111;
        req_port  = '0;
        exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        while (exp_q.size() > 0) begin
            logic [31:0] g;
            g = exp_q.pop_front();
            tick();
            expect_outs($sformatf("t3_grant%0d", g), 4'b0001, 4'(1 << g));
            expect_route("t3_grant", 0, g);
            req_valid[g[1:0]] = 1'b0;
            handshake(int'(g), 1'b1, 1'b1, 1'b1);
            tick();
            expect_outs("t3_bubble", 4'b0000, 4'b0000);
            req_valid[g[1:0]] = 1'b1;
            handshake(int'(g), 1'b0, 1'b0, 1'b0);
        end

        // 4. Four-flit packet input 2 -> output 1, tail stalled 3 cycles.
        do_reset();
        req_valid[2] = 1'b1; req_port[2] = 32'd1;
        tick();
        expect_outs("t4_grant", 4'b0010, 4'b0100);
        expect_route("t4_grant", 1, 32'd2);
        handshake(2, 1'b1, 1'b1, 1'b0);   // head
        tick();
        expect_outs("t4_head", 4'b0010, 4'b0100);
        tick();                           // body 1
        expect_outs("t4_body1", 4'b0010, 4'b0100);
        tick();                           // body 2
        expect_outs("t4_body2", 4'b0010, 4'b0100);
        handshake(2, 1'b1, 1'b0, 1'b1);   // tail presented, not ready
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_outs("t4_stall", 4'b0010, 4'b0100);
            expect_route("t4_stall", 1, 32'd2);
        end
        handshake(2, 1'b1, 1'b1, 1'b1);
        req_valid[2] = 1'b0;
        tick();
        expect_outs("t4_release", 4'b0000, 4'b0000);
        handshake(2, 1'b0, 1'b0, 1'b0);

        // 5. Parallel grants plus out-of-range routes that must never win.
        do_reset();
        req_valid = 4'b0111;
        req_port[0] = 32'd3;
        req_port[1] = 32'd0;
        req_port[2] = 32'd7;
        tick();
        expect_outs("t5_grant", 4'b1001, 4'b0011);
        expect_route("t5_grant", 3, 32'd0);
        expect_route("t5_grant", 0, 32'd1);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        handshake(0, 1'b1, 1'b1, 1'b1);
        handshake(1, 1'b1, 1'b1, 1'b1);
        tick();
        expect_outs("t5_release", 4'b0000, 4'b0000);
        handshake(0, 1'b0, 1'b0, 1'b0);
        handshake(1, 1'b0, 1'b0, 1'b0);
        req_port[2] = 32'h8000_0001;      // aliases output 1 if truncated
        tick();
        tick();
        expect_outs("t5_invalid", 4'b0000, 4'b0000);

        // 6. Reset while outputs 0 and 2 are busy; pointers must restart.
        do_reset();
        req_valid = 4'b1010;
        req_port[1] = 32'd0;
        req_port[3] = 32'd2;
        tick();
        expect_outs("t6_busy", 4'b0101, 4'b1010);
        expect_route("t6_busy", 0, 32'd1);
        expect_route("t6_busy", 2, 32'd3);
        rst_n = 1'b0;
        tick();
        expect_outs("t6_rst", 4'b0000, 4'b0000);
        expect_route("t6_rst", 0, 32'd0);
        expect_route("t6_rst", 2, 32'd0);
        rst_n = 1'b1;
        req_port[3] = 32'd0;               // inputs 1 and 3 both want output 0
        tick();
        expect_outs("t6_regrant", 4'b0001, 4'b0010);
        expect_route("t6_regrant", 0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
